// File: rtl/muldiv_ex.sv
// muldiv_ex: multi-cycle RV32M execution unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU). It handles one operation at a time.
//   clk_in, rst_n_in   : clock (rising edge) and async active-low reset
//   rdy_in             : global enable; low freezes every register
//   flush_in           : kills the in-flight or held operation
//   issue_*            : valid/ready operand handshake from the RS
//                        (op_in, rs1_in, rs2_in, rob_pos_in)
//   res_*              : valid/ready result handshake to the CDB/ROB
//                        (res_out, rob_pos_out)
//   busy_out           : unit is not idle
module muldiv_ex #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 4,
  parameter int MUL_LAT   = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 issue_valid_in,
  output logic                 issue_ready_out,
  input  logic [2:0]           op_in,
  input  logic [XLEN-1:0]      rs1_in,
  input  logic [XLEN-1:0]      rs2_in,
  input  logic [ROB_IDX_W-1:0] rob_pos_in,
  output logic                 res_valid_out,
  input  logic                 res_ready_in,
  output logic [XLEN-1:0]      res_out,
  output logic [ROB_IDX_W-1:0] rob_pos_out,
  output logic                 busy_out
);

  localparam int CNT_W = $clog2(XLEN + MUL_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_END = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_END = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
  logic             q_neg_q, r_neg_q, rem_sel_q;

  // ---------------- issue-side decode ----------------
  logic accept, is_div, div_signed, div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  assign accept     = issue_valid_in & issue_ready_out;
  assign is_div     = op_in[2];
  assign div_signed = ~op_in[0];
  assign div_zero   = (rs2_in == '0);
  assign div_ovf    = div_signed & (rs1_in == INT_MIN) & (&rs2_in);
  assign special    = is_div & (div_zero | div_ovf);
  always_comb begin
    if (div_zero) special_res = op_in[1] ? rs1_in : '1;
    else          special_res = op_in[1] ? '0     : rs1_in;
  end

  // ---------------- multiplier ----------------
  // Operands are extended to 2*XLEN so one unsigned multiply covers all
  // signedness combinations; the low 2*XLEN product bits are exact.
  logic            mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
  logic [XLEN-1:0] mul_p0, mul_last;
  assign mul_sa   = (op_in[1:0] == 2'd1) | (op_in[1:0] == 2'd2);
  assign mul_sb   = (op_in[1:0] == 2'd1);
  assign mul_a    = {{XLEN{mul_sa & rs1_in[XLEN-1]}}, rs1_in};
  assign mul_b    = {{XLEN{mul_sb & rs2_in[XLEN-1]}}, rs2_in};
  assign mul_prod = mul_a * mul_b;
  assign mul_p0   = (op_in[1:0] == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // The first stage samples the issue-side product every enabled edge; only
  // the value captured at the accept edge is ever consumed downstream.
  if (MUL_LAT > 1) begin : g_pipe
    logic [MUL_LAT-1:1][XLEN-1:0] pipe;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) pipe <= '0;
      else if (rdy_in) begin
        pipe[1] <= mul_p0;
        for (int i = 2; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign mul_last = pipe[MUL_LAT-1];
  end else begin : g_nopipe
    assign mul_last = mul_p0;
  end

  // ---------------- divider ----------------
  logic [XLEN-1:0] a_mag, b_mag, rem0, fix_quo, fix_rem;
  logic            bit0, ge;
  logic [XLEN:0]   r_sh, diff;
  assign a_mag = (div_signed & rs1_in[XLEN-1]) ? -rs1_in : rs1_in;
  assign b_mag = (div_signed & rs2_in[XLEN-1]) ? -rs2_in : rs2_in;
  // First restoring step folded into the accept edge: the partial remainder
  // is just the dividend MSB, so it can only reach a divisor of 1.
  assign bit0  = a_mag[XLEN-1] & (b_mag == XLEN'(1));
  assign rem0  = {{(XLEN-1){1'b0}}, a_mag[XLEN-1] & ~bit0};
  assign r_sh  = {rem_q, quo_q[XLEN-1]};
  assign diff  = r_sh - {1'b0, dvs_q};
  assign ge    = ~diff[XLEN];
  assign fix_quo = q_neg_q ? -quo_q : quo_q;
  assign fix_rem = r_neg_q ? -rem_q : rem_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   state_q <= S_IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  state_t acc_state;
  always_comb begin
    if (!is_div)      acc_state = (MUL_LAT == 1) ? S_DONE : S_MUL;
    else if (special) acc_state = S_DONE;
    else              acc_state = S_DIV;
  end

  always_comb begin
    state_d = state_q;
    if (flush_in) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE: if (accept) state_d = acc_state;
        S_MUL:  if (cnt_q == MUL_END) state_d = S_DONE;
        S_DIV:  if (cnt_q == DIV_END) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (res_ready_in) state_d = accept ? acc_state : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    issue_ready_out = rdy_in & ~flush_in &
                      ((state_q == S_IDLE) | ((state_q == S_DONE) & res_ready_in));
    res_valid_out   = (state_q == S_DONE);
    busy_out        = (state_q != S_IDLE);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      rem_sel_q   <= 1'b0;
      res_out     <= '0;
      rob_pos_out <= '0;
    end else if (rdy_in && !flush_in) begin
      if (accept) begin
        rob_pos_out <= rob_pos_in;
        cnt_q       <= CNT_W'(1);
        rem_sel_q   <= op_in[1];
        q_neg_q     <= div_signed & (rs1_in[XLEN-1] ^ rs2_in[XLEN-1]);
        r_neg_q     <= div_signed & rs1_in[XLEN-1];
        dvs_q       <= b_mag;
        rem_q       <= rem0;
        quo_q       <= {a_mag[XLEN-2:0], bit0};
        if (special)                     res_out <= special_res;
        else if (!is_div && MUL_LAT == 1) res_out <= mul_p0;
      end else begin
        case (state_q)
          S_MUL: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == MUL_END) res_out <= mul_last;
          end
          S_DIV: begin
            cnt_q <= cnt_q + CNT_W'(1);
            rem_q <= ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ge};
          end
          S_FIX:   res_out <= rem_sel_q ? fix_rem : fix_quo;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ex.sv
module tb_muldiv_ex;
  logic        clk, rst_n, rdy, flush, issue_valid, issue_ready;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, res;
  logic [3:0]  rob_in, rob_out;
  logic        res_valid, res_ready, busy;

  int n_chk = 0, n_fail = 0;

  muldiv_ex #(.XLEN(32), .ROB_IDX_W(4), .MUL_LAT(3)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .issue_valid_in(issue_valid), .issue_ready_out(issue_ready),
    .op_in(op), .rs1_in(rs1), .rs2_in(rs2), .rob_pos_in(rob_in),
    .res_valid_out(res_valid), .res_ready_in(res_ready),
    .res_out(res), .rob_pos_out(rob_out), .busy_out(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents an op, then counts edges (accept edge = 1)
  // until res_valid is seen high on a negedge.
  task automatic issue_wait(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] rob, output int n);
    issue_valid = 1'b1; op = o; rs1 = a; rs2 = b; rob_in = rob;
    @(posedge clk); n = 1;
    @(negedge clk); issue_valid = 1'b0;
    while (!res_valid && n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [3:0] rob, input int lat,
                     input logic [31:0] exp);
    int n;
    issue_wait(o, a, b, rob, n);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_res"}, res, exp);
    chk({tag, "_rob"}, 32'(rob_out), 32'(rob));
    @(posedge clk); @(negedge clk);   // handshake with res_ready=1
  endtask

  initial begin
    int n;
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; issue_valid = 1'b0; op = '0;
    rs1 = '0; rs2 = '0; rob_in = '0; res_ready = 1'b1;
    #12;
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_res",   res, 32'd0);
    chk("rst_rob",   32'(rob_out), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    chk("idle_ready", 32'(issue_ready), 32'd1);

    // multiply
    run("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 4'd5, 3, 32'hFFFF_FFEB);
    chk("mul_idle_busy",  32'(busy), 32'd0);
    chk("mul_idle_valid", 32'(res_valid), 32'd0);
    run("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 3, 32'hFFFF_FFFE);
    run("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 3, 32'h0000_0000);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 4'd3, 3, 32'hFFFF_FFFF);

    // divide
    run("div",   3'd4, 32'hFFFF_FFF9, 32'd2, 4'd4, 33, 32'hFFFF_FFFD);
    run("rem",   3'd6, 32'hFFFF_FFF9, 32'd2, 4'd6, 33, 32'hFFFF_FFFF);
    run("divu",  3'd5, 32'd100, 32'd7, 4'd7, 33, 32'd14);
    run("remu",  3'd7, 32'd100, 32'd7, 4'd8, 33, 32'd2);
    run("div_nd", 3'd4, 32'd7, 32'hFFFF_FFFE, 4'd9, 33, 32'hFFFF_FFFD);
    run("rem_nd", 3'd6, 32'd7, 32'hFFFF_FFFE, 4'd10, 33, 32'd1);

    // specials
    run("divu0", 3'd5, 32'h1234, 32'd0, 4'd11, 1, 32'hFFFF_FFFF);
    run("remu0", 3'd7, 32'h1234, 32'd0, 4'd12, 1, 32'h1234);
    run("divov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd13, 1, 32'h8000_0000);
    run("remov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd14, 1, 32'd0);

    // hold result, then back-to-back issue on the handshake cycle
    res_ready = 1'b0;
    issue_wait(3'd0, 32'd3, 32'd5, 4'd9, n);
    chk("hold_lat", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_res",   res, 32'd15);
      chk("hold_rob",   32'(rob_out), 32'd9);
    end
    chk("hold_noready", 32'(issue_ready), 32'd0);
    res_ready = 1'b1;
    #1 chk("b2b_ready", 32'(issue_ready), 32'd1);
    run("b2b", 3'd0, 32'd6, 32'd7, 4'd2, 3, 32'd42);

    // flush during divide iteration 10
    issue_valid = 1'b1; op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; rob_in = 4'd4;
    @(posedge clk); @(negedge clk); issue_valid = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    #1 chk("flush_noready", 32'(issue_ready), 32'd0);
    @(posedge clk); @(negedge clk); flush = 1'b0;
    chk("flush_busy",  32'(busy), 32'd0);
    chk("flush_valid", 32'(res_valid), 32'd0);
    run("post_flush", 3'd5, 32'd1000, 32'd3, 4'd5, 33, 32'd333);

    // rdy low for 4 cycles mid-multiply
    issue_valid = 1'b1; op = 3'd0; rs1 = 32'd11; rs2 = 32'd13; rob_in = 4'd7;
    @(posedge clk); n = 1;
    @(negedge clk); issue_valid = 1'b0; rdy = 1'b0;
    repeat (4) begin
      @(posedge clk); n++;
      @(negedge clk);
      chk("frz_ready", 32'(issue_ready), 32'd0);
      chk("frz_busy",  32'(busy), 32'd1);
    end
    rdy = 1'b1;
    while (!res_valid && n < 100) begin @(posedge clk); n++; @(negedge clk); end
    chk("frz_lat", 32'(n), 32'd7);
    chk("frz_res", res, 32'd143);
    chk("frz_rob", 32'(rob_out), 32'd7);
    @(posedge clk); @(negedge clk);
    chk("frz_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_ex.md
Name: muldiv_ex

Overview:
- Multi-cycle RV32M execution unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle integer EX unit.
- Receives ready operands from the reservation station over a valid/ready handshake.
- Returns a ROB-tagged result over a valid/ready handshake to the CDB/ROB arbiter.
- One operation in flight. Killed by pipeline flush on misprediction.

Parameters:
XLEN, 32, operand/result width (even, >=8)
ROB_IDX_W, 4, ROB index width
MUL_LAT, 3, multiply latency in cycles (>=1); product registered through MUL_LAT-1 internal stages plus output register

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
rdy_in  input  1  global enable; low freezes all state, no handshakes complete
flush_in  input  1  misprediction flush; kills in-flight/held op
issue_valid_in  input  1  RS presents an operation
issue_ready_out  output  1  unit can accept this cycle
op_in  input  3  funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
rs1_in  input  XLEN  operand 1
rs2_in  input  XLEN  operand 2
rob_pos_in  input  ROB_IDX_W  destination ROB entry
res_valid_out  output  1  result available
res_ready_in  input  1  consumer takes result
res_out  output  XLEN  result
rob_pos_out  output  ROB_IDX_W  ROB entry of res_out
busy_out  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n_in low): state IDLE; res_valid_out=0, res_out=0, rob_pos_out=0, busy_out=0; internal counters/operands cleared. Reset mid-operation abandons the op with no result.
- States: IDLE, MUL, DIV, FIX, DONE.
- issue_ready_out = rdy_in & !flush_in & (state==IDLE | (state==DONE & res_ready_in)). Combinational.
- Accept: issue_valid_in & issue_ready_out at a rising edge. Latch op, operands and rob_pos.
- Accept transitions:
  - ops 0-3 -> MUL.
  - ops 4-7 with rs2==0 or signed overflow (DIV/REM, rs1=1<<(XLEN-1), rs2=all-ones) -> DONE directly.
  - other divides -> DIV.
- Latency, counted in edges from the accept edge to res_valid_out high:
  - multiply: MUL_LAT
  - normal divide: XLEN+1 (XLEN restoring-iteration cycles on magnitudes, then FIX for sign correction)
  - special divide: 1
- Multiply results use the full 2*XLEN product; sign/zero extension per op:
  - MUL: low XLEN bits.
  - MULH: signed x signed, high half.
  - MULHSU: signed rs1 x unsigned rs2, high half.
  - MULHU: unsigned, high half.
- Signed division truncates toward zero. Remainder takes the sign of the dividend.
- Divide by zero: DIV/DIVU -> all-ones; REM/REMU -> rs1.
- Signed overflow: DIV -> rs1; REM -> 0.
- DONE: res_valid_out=1; res_out and rob_pos_out stable until res_ready_in at an edge.
  - Handshake without new issue -> IDLE.
  - Simultaneous new accept -> MUL/DIV/DONE per the new op (back-to-back, no bubble).
- res_valid_out is 0 in every state other than DONE.
- flush_in at an edge: state -> IDLE from any state; res_valid_out=0 next cycle; no result emitted. Flush has priority over completion and over a same-cycle issue (issue_ready_out already 0).
- rdy_in low: all registers hold, including counters and the MUL pipeline. Outputs hold. flush_in and handshakes are ignored while rdy_in is low.
- busy_out = state!=IDLE (registered).

Test Plan:
- MUL rs1=7 rs2=0xFFFFFFFD, rob_pos=5, res_ready_in=1 -> res_valid_out high exactly 3 edges after accept, res_out=0xFFFFFFEB, rob_pos_out=5, then IDLE.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD at accept+33 edges; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Specials, each at accept+1:
  - DIVU 0x1234/0 -> 0xFFFFFFFF
  - REMU 0x1234/0 -> 0x1234
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM same operands -> 0
- Hold result with res_ready_in=0 for 5 cycles -> res_out/rob_pos_out stable. Then res_ready_in=1 with a new MUL issue the same cycle -> accepted, result after 3 edges.
- Flush mid-operation:
  - flush_in at divide iteration 10 -> IDLE next edge, no res_valid_out; new DIVU issue accepted the following cycle.
  - rdy_in low for 4 cycles mid-multiply -> latency extended by exactly 4.
